// File: rtl/aurora_pkg.sv
// Shared constants, RX checker state encoding and lane-slicing helper.
package aurora_pkg;

  localparam int unsigned LANE_WIDTH = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StHunt   = 2'd1,
    StLocked = 2'd2
  } rx_state_e;

  // Buses are declared [0:N-1] with lane 0 in the MSBs, so lane k starts at bit k*LANE_WIDTH.
  function automatic int unsigned lane_base(input int unsigned k);
    return k * LANE_WIDTH;
  endfunction

endpackage

// File: rtl/aurora_rx_pattern_check.sv
// RX pattern checker: hunts for a run of consistent counter words, then counts
// mismatching and total words while locked.
module aurora_rx_pattern_check
  import aurora_pkg::*;
#(
  parameter int unsigned N_LANE     = 1,
  parameter int unsigned LOCK_COUNT = 4,
  localparam int unsigned DATA_WIDTH = LANE_WIDTH * N_LANE
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_channel_up,
  input  logic                  i_valid_n,
  input  logic [0:DATA_WIDTH-1] i_data,
  output logic                  o_locked,
  output logic [15:0]           o_err_count,
  output logic [31:0]           o_rx_words
);

  localparam logic [3:0] LockRun = 4'(LOCK_COUNT);

  rx_state_e             r_state, w_state_nxt;
  logic [LANE_WIDTH-1:0] r_expected, w_expected_nxt;
  logic [3:0]            r_run, w_run_nxt;
  logic [15:0]           r_err, w_err_nxt;
  logic [31:0]           r_words, w_words_nxt;

  logic [LANE_WIDTH-1:0] w_lane [N_LANE];
  logic                  w_consistent;
  logic                  w_in_seq;

  for (genvar k = 0; k < N_LANE; k++) begin : g_lane
    assign w_lane[k] = i_data[lane_base(k) +: LANE_WIDTH];
  end

  // A word is consistent when every lane carries lane0 plus its lane index.
  always_comb begin
    w_consistent = 1'b1;
    for (int unsigned k = 1; k < N_LANE; k++) begin
      if (w_lane[k] != w_lane[0] + LANE_WIDTH'(k)) w_consistent = 1'b0;
    end
  end

  assign w_in_seq = (w_lane[0] == r_expected);

  // Next-state and counter updates; channel down overrides everything, including a valid word.
  always_comb begin
    w_state_nxt    = r_state;
    w_expected_nxt = r_expected;
    w_run_nxt      = r_run;
    w_err_nxt      = r_err;
    w_words_nxt    = r_words;
    if (!i_channel_up) begin
      w_state_nxt    = StIdle;
      w_expected_nxt = '0;
      w_run_nxt      = '0;
    end else begin
      unique case (r_state)
        StIdle: w_state_nxt = StHunt;
        StHunt: begin
          if (!i_valid_n) begin
            if (!w_consistent) begin
              w_run_nxt = '0;
            end else begin
              w_expected_nxt = w_lane[0] + LANE_WIDTH'(1);
              if ((r_run != 4'd0) && !w_in_seq) begin
                w_run_nxt = '0;
              end else begin
                w_run_nxt = r_run + 4'd1;
                if (r_run + 4'd1 == LockRun) w_state_nxt = StLocked;
              end
            end
          end
        end
        StLocked: begin
          if (!i_valid_n) begin
            w_words_nxt    = r_words + 32'd1;
            // Reseed on every word so a single slip costs one error, not a flood.
            w_expected_nxt = w_lane[0] + LANE_WIDTH'(1);
            if (!(w_consistent && w_in_seq) && (r_err != 16'hFFFF)) begin
              w_err_nxt = r_err + 16'd1;
            end
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_expected <= '0;
      r_run      <= '0;
      r_err      <= '0;
      r_words    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_expected <= w_expected_nxt;
      r_run      <= w_run_nxt;
      r_err      <= w_err_nxt;
      r_words    <= w_words_nxt;
    end
  end

  assign o_locked    = (r_state == StLocked);
  assign o_err_count = r_err;
  assign o_rx_words  = r_words;

endmodule

// File: rtl/aurora_stream_checker.sv
// Aurora user-side traffic generator/checker: incrementing TX pattern, RX pattern
// check, status counters and board LEDs.
module aurora_stream_checker
  import aurora_pkg::*;
#(
  parameter int unsigned N_LANE        = 1,
  parameter int unsigned LOCK_COUNT    = 4,
  parameter int unsigned HEARTBEAT_BIT = 24,
  localparam int unsigned DATA_WIDTH   = LANE_WIDTH * N_LANE
) (
  input  logic                  USER_CLK,
  input  logic                  RESET_N,
  input  logic                  CHANNEL_UP,
  input  logic [N_LANE-1:0]     LANE_UP,
  input  logic                  HARD_ERR,
  input  logic                  SOFT_ERR,
  output logic [0:DATA_WIDTH-1] TX_D,
  output logic                  TX_SRC_RDY_N,
  input  logic                  TX_DST_RDY_N,
  input  logic [0:DATA_WIDTH-1] RX_D,
  input  logic                  RX_SRC_RDY_N,
  output logic                  LOCKED,
  output logic [15:0]           ERR_COUNT,
  output logic [31:0]           RX_WORDS,
  output logic [7:0]            GPIO_LED
);

  localparam int unsigned HbWidth = HEARTBEAT_BIT + 1;

  logic [LANE_WIDTH-1:0] r_tx_cnt;
  logic                  r_tx_src_rdy_n;
  logic [HbWidth-1:0]    r_hb;
  logic [7:0]            r_led;

  logic                  w_locked;
  logic [15:0]           w_err_count;
  logic [31:0]           w_rx_words;

  // TX counter advances only on an accepted word; channel down restarts the pattern at 0.
  always_ff @(posedge USER_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_tx_cnt       <= '0;
      r_tx_src_rdy_n <= 1'b1;
    end else if (!CHANNEL_UP) begin
      r_tx_cnt       <= '0;
      r_tx_src_rdy_n <= 1'b1;
    end else begin
      r_tx_src_rdy_n <= 1'b0;
      if (!r_tx_src_rdy_n && !TX_DST_RDY_N) r_tx_cnt <= r_tx_cnt + LANE_WIDTH'(1);
    end
  end

  // Data is zeroed while not offered so the bus reads 0 out of reset on any lane count.
  for (genvar k = 0; k < N_LANE; k++) begin : g_tx_lane
    assign TX_D[lane_base(k) +: LANE_WIDTH] =
        r_tx_src_rdy_n ? '0 : r_tx_cnt + LANE_WIDTH'(k);
  end

  assign TX_SRC_RDY_N = r_tx_src_rdy_n;

  // Free-running heartbeat counter.
  always_ff @(posedge USER_CLK or negedge RESET_N) begin
    if (!RESET_N) r_hb <= '0;
    else          r_hb <= r_hb + HbWidth'(1);
  end

  // Registered status LEDs; error bits 3/4 are sticky until reset.
  always_ff @(posedge USER_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_led <= '0;
    end else begin
      r_led <= {|LANE_UP,
                &LANE_UP,
                r_hb[HEARTBEAT_BIT],
                r_led[4] | SOFT_ERR,
                r_led[3] | HARD_ERR,
                (w_err_count != 16'd0),
                w_locked,
                CHANNEL_UP};
    end
  end

  assign GPIO_LED = r_led;

  aurora_rx_pattern_check #(
    .N_LANE     (N_LANE),
    .LOCK_COUNT (LOCK_COUNT)
  ) u_rx_check (
    .i_clk        (USER_CLK),
    .i_rst_n      (RESET_N),
    .i_channel_up (CHANNEL_UP),
    .i_valid_n    (RX_SRC_RDY_N),
    .i_data       (RX_D),
    .o_locked     (w_locked),
    .o_err_count  (w_err_count),
    .o_rx_words   (w_rx_words)
  );

  assign LOCKED    = w_locked;
  assign ERR_COUNT = w_err_count;
  assign RX_WORDS  = w_rx_words;

endmodule

// File: tb/tb_aurora_stream_checker.sv
// Directed bench for aurora_stream_checker with two lanes and LOCK_COUNT=4.
module tb_aurora_stream_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        channel_up;
  logic [1:0]  lane_up;
  logic        hard_err;
  logic        soft_err;
  logic [0:31] tx_d;
  logic        tx_src_rdy_n;
  logic        tx_dst_rdy_n;
  logic [0:31] rx_d;
  logic        rx_src_rdy_n;
  logic        locked;
  logic [15:0] err_count;
  logic [31:0] rx_words;
  logic [7:0]  gpio_led;

  int checks   = 0;
  int failures = 0;

  aurora_stream_checker #(
    .N_LANE        (2),
    .LOCK_COUNT    (4),
    .HEARTBEAT_BIT (24)
  ) dut (
    .USER_CLK     (clk),
    .RESET_N      (rst_n),
    .CHANNEL_UP   (channel_up),
    .LANE_UP      (lane_up),
    .HARD_ERR     (hard_err),
    .SOFT_ERR     (soft_err),
    .TX_D         (tx_d),
    .TX_SRC_RDY_N (tx_src_rdy_n),
    .TX_DST_RDY_N (tx_dst_rdy_n),
    .RX_D         (rx_d),
    .RX_SRC_RDY_N (rx_src_rdy_n),
    .LOCKED       (locked),
    .ERR_COUNT    (err_count),
    .RX_WORDS     (rx_words),
    .GPIO_LED     (gpio_led)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; channel_up = 1'b0; lane_up = 2'b00; hard_err = 1'b0; soft_err = 1'b0;
    tx_dst_rdy_n = 1'b1; rx_d = '0; rx_src_rdy_n = 1'b1;
    step(); step();
    checks++; if (tx_src_rdy_n !== 1'b1) begin failures++;
      $display("FAIL reset_tx_src_rdy_n: got %0b want 1", tx_src_rdy_n); end
    checks++; if (tx_d !== 32'd0) begin failures++;
      $display("FAIL reset_tx_d: got %h want 0", tx_d); end
    checks++; if (locked !== 1'b0) begin failures++;
      $display("FAIL reset_locked: got %0b want 0", locked); end
    checks++; if (err_count !== 16'd0 || rx_words !== 32'd0) begin failures++;
      $display("FAIL reset_counters: got err=%0d words=%0d want 0/0", err_count, rx_words); end
    checks++; if (gpio_led !== 8'h00) begin failures++;
      $display("FAIL reset_led: got %h want 00", gpio_led); end
    rst_n = 1'b1;
    step();
    checks++; if (tx_src_rdy_n !== 1'b1 || locked !== 1'b0) begin failures++;
      $display("FAIL post_reset_idle: got src=%0b lock=%0b want 1/0", tx_src_rdy_n, locked); end
  endtask

  task automatic test_tx_handshake();
    logic       dst [5];
    logic [15:0] exp0 [5];
    dst  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp0 = '{16'd0, 16'd1, 16'd2, 16'd2, 16'd3};
    channel_up = 1'b1; lane_up = 2'b11; tx_dst_rdy_n = 1'b1;
    #1;
    checks++; if (tx_src_rdy_n !== 1'b1) begin failures++;
      $display("FAIL tx_src_before_edge: got %0b want 1", tx_src_rdy_n); end
    step();
    checks++; if (tx_src_rdy_n !== 1'b0) begin failures++;
      $display("FAIL tx_src_after_edge: got %0b want 0", tx_src_rdy_n); end
    checks++; if (tx_d !== 32'h0000_0001) begin failures++;
      $display("FAIL tx_first_word: got %h want 00000001", tx_d); end
    for (int i = 0; i < 5; i++) begin
      tx_dst_rdy_n = dst[i];
      step();
      checks++; if (tx_d[0:15] !== exp0[i]) begin failures++;
        $display("FAIL tx_seq[%0d]: got %h want %h", i, tx_d[0:15], exp0[i]); end
    end
    tx_dst_rdy_n = 1'b1;
    step();
    checks++; if (tx_d !== 32'h0003_0004) begin failures++;
      $display("FAIL tx_hold_lanes: got %h want 00030004", tx_d); end
    checks++; if ((gpio_led & 8'hDF) !== 8'hC1) begin failures++;
      $display("FAIL led_link_up: got %h want C1 (bit5 masked)", gpio_led & 8'hDF); end
  endtask

  task automatic test_lock();
    logic [31:0] w [7];
    w = '{32'h0001_0002, 32'h0002_0003, 32'h0009_0009,
          32'h0005_0006, 32'h0006_0007, 32'h0007_0008, 32'h0008_0009};
    for (int i = 0; i < 7; i++) begin
      rx_d = w[i]; rx_src_rdy_n = 1'b0;
      step();
      if (i == 2 || i == 5) begin
        checks++; if (locked !== 1'b0) begin failures++;
          $display("FAIL lock_early[%0d]: got %0b want 0", i, locked); end
      end
    end
    rx_src_rdy_n = 1'b1; rx_d = 32'hDEAD_BEEF;
    checks++; if (locked !== 1'b1) begin failures++;
      $display("FAIL lock_reached: got %0b want 1", locked); end
    checks++; if (err_count !== 16'd0 || rx_words !== 32'd0) begin failures++;
      $display("FAIL lock_counters: got err=%0d words=%0d want 0/0", err_count, rx_words); end
  endtask

  task automatic test_locked_errors();
    logic [31:0] w [5];
    logic [15:0] exp_err [5];
    w = '{32'h000A_000B, 32'h0014_0015, 32'h0015_0016, 32'h0016_0063, 32'hFFFD_FFFE};
    exp_err = '{16'd1, 16'd2, 16'd2, 16'd3, 16'd4};
    for (int i = 0; i < 5; i++) begin
      rx_d = w[i]; rx_src_rdy_n = 1'b0;
      step();
      checks++; if (err_count !== exp_err[i] || rx_words !== 32'(i + 1)) begin failures++;
        $display("FAIL locked_err[%0d]: got err=%0d words=%0d want %0d/%0d",
                 i, err_count, rx_words, exp_err[i], i + 1); end
    end
    rx_src_rdy_n = 1'b1;
    checks++; if (locked !== 1'b1) begin failures++;
      $display("FAIL locked_stays: got %0b want 1", locked); end
  endtask

  task automatic test_wrap_gaps();
    logic [31:0] w [6];
    logic        v [6];
    logic [31:0] exp_words [6];
    w = '{32'hFFFE_FFFF, 32'hDEAD_BEEF, 32'hFFFF_0000, 32'h1234_5678, 32'h0BAD_F00D,
          32'h0000_0001};
    v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_words = '{32'd6, 32'd6, 32'd7, 32'd7, 32'd7, 32'd8};
    for (int i = 0; i < 6; i++) begin
      rx_d = w[i]; rx_src_rdy_n = ~v[i];
      step();
      checks++; if (rx_words !== exp_words[i]) begin failures++;
        $display("FAIL wrap_words[%0d]: got %0d want %0d", i, rx_words, exp_words[i]); end
    end
    rx_src_rdy_n = 1'b1;
    checks++; if (err_count !== 16'd4) begin failures++;
      $display("FAIL wrap_no_err: got %0d want 4", err_count); end
  endtask

  task automatic test_channel_drop();
    rx_d = 32'h0001_0002; rx_src_rdy_n = 1'b0; channel_up = 1'b0;
    step();
    rx_src_rdy_n = 1'b1;
    checks++; if (locked !== 1'b0) begin failures++;
      $display("FAIL drop_unlock: got %0b want 0", locked); end
    checks++; if (rx_words !== 32'd8 || err_count !== 16'd4) begin failures++;
      $display("FAIL drop_counters: got err=%0d words=%0d want 4/8", err_count, rx_words); end
    checks++; if (tx_src_rdy_n !== 1'b1 || tx_d !== 32'd0) begin failures++;
      $display("FAIL drop_tx: got src=%0b d=%h want 1/0", tx_src_rdy_n, tx_d); end
    channel_up = 1'b1;
    step();
    checks++; if (tx_src_rdy_n !== 1'b0 || tx_d !== 32'h0000_0001) begin failures++;
      $display("FAIL drop_tx_restart: got src=%0b d=%h want 0/00000001", tx_src_rdy_n, tx_d); end
    checks++; if ((gpio_led & 8'hDF) !== 8'hC5) begin failures++;
      $display("FAIL drop_led: got %h want C5 (bit5 masked)", gpio_led & 8'hDF); end
  endtask

  task automatic test_sticky_and_async_reset();
    hard_err = 1'b1; step(); hard_err = 1'b0; step(); step();
    checks++; if (gpio_led[3] !== 1'b1 || gpio_led[4] !== 1'b0) begin failures++;
      $display("FAIL sticky_hard: got led3=%0b led4=%0b want 1/0", gpio_led[3], gpio_led[4]); end
    soft_err = 1'b1; step(); soft_err = 1'b0; step(); step();
    checks++; if ((gpio_led & 8'hDF) !== 8'hDD) begin failures++;
      $display("FAIL sticky_both: got %h want DD (bit5 masked)", gpio_led & 8'hDF); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (tx_src_rdy_n !== 1'b1 || tx_d !== 32'd0 || locked !== 1'b0) begin failures++;
      $display("FAIL async_reset_tx: got src=%0b d=%h lock=%0b want 1/0/0",
               tx_src_rdy_n, tx_d, locked); end
    checks++; if (err_count !== 16'd0 || rx_words !== 32'd0 || gpio_led !== 8'h00) begin
      failures++;
      $display("FAIL async_reset_status: got err=%0d words=%0d led=%h want 0/0/00",
               err_count, rx_words, gpio_led); end
    step();
    rst_n = 1'b1; channel_up = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_tx_handshake();
    test_lock();
    test_locked_errors();
    test_wrap_gaps();
    test_channel_drop();
    test_sticky_and_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
